// File: rtl/decrypted_image_display.sv
// decrypted_image_display: 640x480 VGA scan-out of a 160x120 RGB332 image held in a
// synchronous RAM. Each source pixel is replicated 2**SCALE_SHIFT times in both
// directions. The image is shown only while the decrypter reports done. A new
// display always starts on a frame boundary. Blanking starts at once when done drops.
module decrypted_image_display #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 120,
  parameter int SCALE_SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_en,
  input  logic        done,
  output logic [14:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  vga_r,
  output logic [2:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        frame_start,
  output logic        showing
);

  // Visible area is the source image scaled up; the totals and sync windows are fixed 640x480@60 timing.
  localparam logic [9:0]  H_VIS    = 10'(IMG_W << SCALE_SHIFT);
  localparam logic [9:0]  V_VIS    = 10'(IMG_H << SCALE_SHIFT);
  localparam logic [9:0]  H_LAST   = 10'd799;
  localparam logic [9:0]  V_LAST   = 10'd524;
  localparam logic [9:0]  HS_FIRST = 10'd656;
  localparam logic [9:0]  HS_LAST  = 10'd751;
  localparam logic [9:0]  VS_FIRST = 10'd490;
  localparam logic [9:0]  VS_LAST  = 10'd491;
  localparam logic [14:0] IMG_W_15 = 15'(IMG_W);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [1:0]  state_q, state_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        pix_vis_q, pix_vis_d;
  logic        hs_early_q, hs_early_d;
  logic        vs_early_q, vs_early_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  rgb_q, rgb_d;
  logic        frame_start_q, frame_start_d;
  logic        showing_q, showing_d;

  logic        visible;
  logic        in_show;
  logic        at_frame_end;
  logic [14:0] row_idx;
  logic [14:0] col_idx;
  logic [14:0] addr_calc;

  // Decode of the current scan position and the RAM address of the source pixel under it.
  always_comb begin
    visible      = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    in_show      = (state_q == ST_SHOW);
    at_frame_end = (hcount_q == H_LAST) && (vcount_q == V_LAST);
    row_idx      = 15'(vcount_q >> SCALE_SHIFT);
    col_idx      = 15'(hcount_q >> SCALE_SHIFT);
    addr_calc    = row_idx * IMG_W_15 + col_idx;
  end

  // Scan counters run in every state; they step only on pixel ticks. frame_start marks the wrap to (0,0).
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (pixel_en) begin
      frame_start_d = at_frame_end;
      if (hcount_q == H_LAST) begin
        hcount_d = 10'd0;
        vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  // Display control: arm on done, start showing only at a frame boundary, drop out as soon as done falls.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (done) state_d = ST_ARMED;
      ST_ARMED: begin
        if (!done) state_d = ST_IDLE;
        else if (frame_start_q) state_d = ST_SHOW;
      end
      ST_SHOW:  if (!done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    showing_d = (state_d == ST_SHOW);
  end

  // Two-stage pixel pipeline: tick N issues the RAM read and early sync; tick N+1 emits RGB with the matching sync.
  always_comb begin
    rd_addr_d  = rd_addr_q;
    pix_vis_d  = pix_vis_q;
    hs_early_d = hs_early_q;
    vs_early_d = vs_early_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    rgb_d      = rgb_q;
    if (pixel_en) begin
      pix_vis_d  = visible && in_show;
      rd_addr_d  = (visible && in_show) ? addr_calc : 15'd0;
      hs_early_d = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
      vs_early_d = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
      hsync_d    = hs_early_q;
      vsync_d    = vs_early_q;
      rgb_d      = (pix_vis_q && in_show) ? rd_data : 8'd0;
    end
  end

  // All state and outputs are registered; reset puts the display into a blank, idle, sync-inactive condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      state_q       <= ST_IDLE;
      rd_addr_q     <= 15'd0;
      pix_vis_q     <= 1'b0;
      hs_early_q    <= 1'b1;
      vs_early_q    <= 1'b1;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      rgb_q         <= 8'd0;
      frame_start_q <= 1'b0;
      showing_q     <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      pix_vis_q     <= pix_vis_d;
      hs_early_q    <= hs_early_d;
      vs_early_q    <= vs_early_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      showing_q     <= showing_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[7:5];
  assign vga_g       = rgb_q[4:2];
  assign vga_b       = rgb_q[1:0];
  assign frame_start = frame_start_q;
  assign showing     = showing_q;

endmodule

// File: tb/tb_decrypted_image_display.sv
// tb_decrypted_image_display: directed bench for the VGA image display.
// A reference model of the scan position tracks every pixel tick. Fixed pixels are
// checked against hand-computed address/colour records. Short hand-written sequences
// cover arming, dropping done and a mid-frame reset.
module tb_decrypted_image_display;

  localparam int IMG_W       = 160;
  localparam int IMG_H       = 120;
  localparam int SCALE_SHIFT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        pixel_en;
  logic        done;
  logic [14:0] rd_addr;
  logic [7:0]  rd_data;
  logic        hsync;
  logic        vsync;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        frame_start;
  logic        showing;

  int total = 0;
  int bad   = 0;

  decrypted_image_display #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H),
    .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pixel_en(pixel_en),
    .done(done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .hsync(hsync),
    .vsync(vsync),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start),
    .showing(showing)
  );

  always #5 clk = ~clk;

  // One directed record: the scan position, then the expected read address and the colour emitted one tick later.
  typedef struct {
    int          h;
    int          v;
    logic [14:0] addr;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
  } vec_t;

  vec_t vecs[9];

  // Reference model of the scan: (mh,mv) is the pixel the next tick handles; (ph,pv) is the one before it.
  int          mh;
  int          mv;
  int          ph;
  int          pv;
  bit          pvalid;
  bit          pshow;
  bit          showNow;
  logic [14:0] lastAddr;

  int addrErr = 0;
  int rgbErr  = 0;
  int hsErr   = 0;
  int vsErr   = 0;
  int fsErr   = 0;
  int showErr = 0;
  int hsLow;
  int vsLow;
  int ticksSinceFs;

  // RAM contents: address 0 holds 8'hE3, other words are distinct patterns.
  function automatic logic [7:0] ramByte(input logic [14:0] a);
    return a[7:0] ^ 8'hE3;
  endfunction

  function automatic logic [14:0] expectedAddr(input int h, input int v);
    return 15'(((v >> SCALE_SHIFT) * IMG_W) + (h >> SCALE_SHIFT));
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    mh           = 0;
    mv           = 0;
    ph           = 0;
    pv           = 0;
    pvalid       = 1'b0;
    pshow        = 1'b0;
    showNow      = 1'b0;
    lastAddr     = 15'd0;
    hsLow        = 0;
    vsLow        = 0;
    ticksSinceFs = 0;
  endtask

  // One pixel tick (pixel_en high for one clk, then low for one clk), with every output compared to the model.
  task automatic pixelTick();
    bit          vis;
    bit          expHs;
    bit          expVs;
    bit          expFs;
    logic [14:0] expAddr;
    logic [7:0]  expRgb;
    pixel_en = 1'b1;
    @(posedge clk);
    #1;
    pixel_en = 1'b0;
    vis     = (mh < 640) && (mv < 480);
    expAddr = (vis && showNow) ? expectedAddr(mh, mv) : 15'd0;
    expHs   = pvalid ? !((ph >= 656) && (ph <= 751)) : 1'b1;
    expVs   = pvalid ? !((pv >= 490) && (pv <= 491)) : 1'b1;
    expRgb  = (pvalid && pshow && showNow) ? ramByte(lastAddr) : 8'd0;
    expFs   = (mh == 799) && (mv == 524);
    if (rd_addr !== expAddr) addrErr++;
    if (hsync !== expHs) hsErr++;
    if (vsync !== expVs) vsErr++;
    if ({vga_r, vga_g, vga_b} !== expRgb) rgbErr++;
    if (frame_start !== expFs) fsErr++;
    if (showing !== showNow) showErr++;
    if (hsync === 1'b0) hsLow++;
    if (vsync === 1'b0) vsLow++;
    ticksSinceFs++;
    rd_data = ramByte(rd_addr);
    if (expFs) begin
      checkOutput("frame_period_ticks", ticksSinceFs, 420000);
      checkOutput("hsync_low_ticks_per_frame", hsLow, 50400);
      checkOutput("vsync_low_ticks_per_frame", vsLow, 1600);
      ticksSinceFs = 0;
      hsLow        = 0;
      vsLow        = 0;
    end
    ph       = mh;
    pv       = mv;
    pvalid   = 1'b1;
    pshow    = vis && showNow;
    lastAddr = expAddr;
    if (mh == 799) begin
      mh = 0;
      mv = (mv == 524) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    @(posedge clk);
    #1;
    if (frame_start !== 1'b0) fsErr++;
  endtask

  task automatic runTo(input int h, input int v);
    int guard = 0;
    while (!((mh == h) && (mv == v)) && (guard < 430000)) begin
      pixelTick();
      guard++;
    end
    if (!((mh == h) && (mv == v))) checkOutput("runTo_bound", guard, 0);
  endtask

  // Apply one record: tick the target pixel, check its read address, tick once more, check its colour.
  task automatic applyStimulus(input vec_t t);
    runTo(t.h, t.v);
    pixelTick();
    checkOutput($sformatf("addr_%0d_%0d", t.h, t.v), rd_addr, t.addr);
    pixelTick();
    checkOutput($sformatf("rgb_%0d_%0d", t.h, t.v), {vga_r, vga_g, vga_b}, {t.r, t.g, t.b});
  endtask

  initial begin
    reset    = 1'b1;
    pixel_en = 1'b0;
    done     = 1'b0;
    rd_data  = 8'd0;
    resetModel();

    vecs[0] = '{0,   0,   15'd0,     3'd7, 3'd0, 2'd3};
    vecs[1] = '{3,   0,   15'd0,     3'd7, 3'd0, 2'd3};
    vecs[2] = '{4,   0,   15'd1,     3'd7, 3'd0, 2'd2};
    vecs[3] = '{640, 0,   15'd0,     3'd0, 3'd0, 2'd0};
    vecs[4] = '{8,   1,   15'd2,     3'd7, 3'd0, 2'd1};
    vecs[5] = '{0,   3,   15'd0,     3'd7, 3'd0, 2'd3};
    vecs[6] = '{3,   3,   15'd0,     3'd7, 3'd0, 2'd3};
    vecs[7] = '{4,   4,   15'd161,   3'd2, 3'd0, 2'd2};
    vecs[8] = '{639, 479, 15'd19199, 3'd0, 3'd7, 2'd0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_hsync", hsync, 1);
    checkOutput("reset_vsync", vsync, 1);
    checkOutput("reset_rgb", {vga_r, vga_g, vga_b}, 0);
    checkOutput("reset_frame_start", frame_start, 0);
    checkOutput("reset_showing", showing, 0);
    reset = 1'b0;

    // Arm mid-frame: nothing is shown until the next frame boundary.
    runTo(0, 2);
    done = 1'b1;
    runTo(0, 300);
    checkOutput("armed_showing", showing, 0);
    runTo(799, 524);
    pixelTick();
    checkOutput("show_after_frame_start", showing, 1);
    showNow = 1'b1;

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Asynchronous reset in the middle of a displayed frame, inside both sync pulses.
    runTo(700, 490);
    pixelTick();
    checkOutput("pre_reset_showing", showing, 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_rd_addr", rd_addr, 0);
    checkOutput("async_reset_hsync", hsync, 1);
    checkOutput("async_reset_vsync", vsync, 1);
    checkOutput("async_reset_rgb", {vga_r, vga_g, vga_b}, 0);
    checkOutput("async_reset_frame_start", frame_start, 0);
    checkOutput("async_reset_showing", showing, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    resetModel();

    // Done stays high through reset: display comes back only after a full frame.
    runTo(0, 100);
    checkOutput("rearmed_showing", showing, 0);
    runTo(799, 524);
    pixelTick();
    checkOutput("show_after_reset_frame", showing, 1);
    showNow = 1'b1;
    pixelTick();
    checkOutput("first_visible_addr", rd_addr, 0);

    // Drop done mid-line while showing.
    runTo(300, 2);
    checkOutput("pre_drop_showing", showing, 1);
    done = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("drop_showing", showing, 0);
    showNow = 1'b0;
    pixelTick();
    checkOutput("drop_rgb_next_tick", {vga_r, vga_g, vga_b}, 0);
    checkOutput("drop_addr", rd_addr, 0);
    runTo(0, 6);

    checkOutput("addr_stream_errors", addrErr, 0);
    checkOutput("rgb_stream_errors", rgbErr, 0);
    checkOutput("hsync_stream_errors", hsErr, 0);
    checkOutput("vsync_stream_errors", vsErr, 0);
    checkOutput("frame_start_stream_errors", fsErr, 0);
    checkOutput("showing_stream_errors", showErr, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decrypted_image_display.md
DECRYPTED_IMAGE_DISPLAY -- requirements
Module: decrypted_image_display

Interface
REQ-001 SHALL have parameter IMG_W, default 160, source image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 120, source image height in pixels.
REQ-003 SHALL have parameter SCALE_SHIFT, default 2, log2 of the upscale factor; 160x120 maps to 640x480.
REQ-004 SHALL have port clk, input, 1, system clock; the only clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port pixel_en, input, 1, pixel-rate tick; never high on two consecutive clk cycles.
REQ-007 SHALL have port done, input, 1, level from the decrypter; high means the image RAM holds a complete decrypted image.
REQ-008 SHALL have port rd_addr, output, 15, image RAM read address.
REQ-009 SHALL have port rd_data, input, 8, image RAM read data, valid one clk after rd_addr changes (synchronous RAM).
REQ-010 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-011 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-012 SHALL have port vga_r, output, 3, red.
REQ-013 SHALL have port vga_g, output, 3, green.
REQ-014 SHALL have port vga_b, output, 2, blue.
REQ-015 SHALL have port frame_start, output, 1, one-clk pulse at the start of each frame.
REQ-016 SHALL have port showing, output, 1, high while image pixels are being displayed.

Function
REQ-017 SHALL hold hcount 0..799 and vcount 0..524, advancing only on clk cycles with pixel_en high; hcount wraps 799->0 and increments vcount; vcount wraps 524->0.
REQ-018 SHALL treat hcount<640 and vcount<480 as visible; hsync low for hcount 656..751; vsync low for vcount 490..491.
REQ-019 SHALL pulse frame_start for exactly one clk, on the pixel_en cycle where the counters go from (799,524) to (0,0).
REQ-020 SHALL implement three states: IDLE, ARMED and SHOW.
REQ-021 SHALL transition IDLE->ARMED when done is high.
REQ-022 SHALL transition ARMED->SHOW on the frame_start cycle if done is still high, and ARMED->IDLE if done is low.
REQ-023 SHALL transition SHOW->IDLE on the first clk in which done is low, blanking from the next pixel tick without waiting for a frame boundary.
REQ-024 SHALL drive showing high only in SHOW.
REQ-025 SHALL, on each pixel_en cycle in SHOW with the counters visible, register rd_addr = (vcount>>SCALE_SHIFT)*IMG_W + (hcount>>SCALE_SHIFT), computed without overflow in 15 bits (max 19199).
REQ-026 SHALL register rd_addr = 0 on pixel_en cycles outside the visible area or outside SHOW.
REQ-027 SHALL, on the next pixel_en, register rd_data[7:5]->vga_r, rd_data[4:2]->vga_g and rd_data[1:0]->vga_b for a visible pixel in SHOW, and 0 otherwise.
REQ-028 SHALL delay hsync and vsync by one pixel tick so that sync and RGB for pixel (h,v) appear on the same tick (pipeline latency one pixel tick).
REQ-029 SHALL keep the sync counters running in every state, so sync timing is never interrupted by done activity.
REQ-030 SHALL change all outputs only on clk rising edges, registered, with no combinational paths from inputs to outputs.

Reset
REQ-031 SHALL, while reset is high, asynchronously force: state IDLE, hcount=0, vcount=0, rd_addr=0, vga_r/g/b=0, hsync=1, vsync=1, frame_start=0, showing=0.
REQ-032 SHALL resume from hcount=0, vcount=0 on the first pixel_en after reset deasserts; reset mid-frame or mid-SHOW discards all state and any pending ARMED.

Verification
REQ-033 Sync: reset, run 2 frames with pixel_en every 4th clk -> hsync low for exactly 96 ticks per line, vsync low for 2 lines (1600 ticks), frame_start every 420000 ticks.
REQ-034 Arming: done raised mid-frame -> showing stays 0 until the next frame_start, then is 1; the first visible tick requests rd_addr=0.
REQ-035 Addressing: in SHOW, pixel (639,479) -> rd_addr=19199; pixel (4,4) -> rd_addr=161; pixels (0..3,0..3) all -> rd_addr=0.
REQ-036 Colour: RAM model returns 8'hE3 -> vga_r=7, vga_g=0, vga_b=3 one tick later, aligned with the delayed hsync/vsync; outside the visible area RGB=0.
REQ-037 Drop: done falls mid-line in SHOW -> showing=0 next clk, RGB=0 from the next tick, and sync timing is unchanged.
REQ-038 Reset mid-SHOW: assert reset asynchronously between clk edges -> all outputs take their REQ-031 values immediately; after release with done high, SHOW resumes only after the next frame_start.
